// File: rtl/sat_accum_sched_if.sv
// Bundle of per-channel sample handshake, clears and accumulator/writeback outputs
// for sat_accum_sched. The slave modport is the accumulator side.
interface sat_accum_sched_if #(
    parameter int N_CH  = 4,
    parameter int IN_W  = 16,
    parameter int ACC_W = 24
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [N_CH*IN_W-1:0]  in_data;
    logic [N_CH-1:0]       clr;
    logic [N_CH*ACC_W-1:0] acc_data;
    logic                  wr_valid;
    logic [CH_W-1:0]       wr_ch;
    logic [7:0]            sat_cnt;
    logic                  sat_cnt_clr;
    logic [N_CH-1:0]       sat_flag;

    modport master (
        output in_valid, in_data, clr, sat_cnt_clr,
        input  in_ready, acc_data, wr_valid, wr_ch, sat_cnt, sat_flag
    );

    modport slave (
        input  in_valid, in_data, clr, sat_cnt_clr,
        output in_ready, acc_data, wr_valid, wr_ch, sat_cnt, sat_flag
    );
endinterface

// File: rtl/sat_accum_sched.sv
// Round-robin shared saturating accumulator: N_CH channels share one add/saturate stage.
// Define SAT_STICKY_EN to build the sticky per-channel saturation flags.
module sat_accum_sched #(
    parameter int N_CH  = 4,
    parameter int IN_W  = 16,
    parameter int ACC_W = 24
) (
    input logic              clk,
    input logic              rst_n,
    sat_accum_sched_if.slave bus
);
    localparam int CH_W = $clog2(N_CH);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int k);
        int sum;
        sum = (int'(base) + k) % N_CH;
        return CH_W'(sum);
    endfunction

    logic [CH_W-1:0]         r_last;
    logic [N_CH-1:0]         w_grant;
    logic [CH_W-1:0]         w_grant_ch;
    logic                    w_grant_any;

    logic                    r_s1_valid;
    logic [CH_W-1:0]         r_s1_ch;
    logic signed [IN_W-1:0]  r_s1_data;

    logic signed [ACC_W-1:0] w_acc [N_CH];
    logic signed [ACC_W-1:0] w_acc_sel;
    logic signed [ACC_W:0]   w_sum;
    logic                    w_ovf;
    logic signed [ACC_W-1:0] w_wb_value;
    logic                    w_sat_event;

    logic                    r_wr_valid;
    logic [CH_W-1:0]         r_wr_ch;
    logic [7:0]              r_sat_cnt;

    // Priority starts just after the last granted channel; nothing is granted while in reset.
    always_comb begin
        w_grant     = '0;
        w_grant_ch  = r_last;
        w_grant_any = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            if (!w_grant_any && bus.in_valid[rr_idx(r_last, k)]) begin
                w_grant_any = 1'b1;
                w_grant_ch  = rr_idx(r_last, k);
            end
        end
        w_grant[w_grant_ch] = w_grant_any & rst_n;
    end

    assign bus.in_ready = w_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_grant_any;
            if (w_grant_any) begin
                r_last    <= w_grant_ch;
                r_s1_ch   <= w_grant_ch;
                r_s1_data <= bus.in_data[w_grant_ch*IN_W +: IN_W];
            end
        end
    end

    assign w_acc_sel = w_acc[r_s1_ch];
    assign w_sum     = {w_acc_sel[ACC_W-1], w_acc_sel}
                     + {{(ACC_W+1-IN_W){r_s1_data[IN_W-1]}}, r_s1_data};
    assign w_ovf     = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    always_comb begin
        w_wb_value = w_sum[ACC_W-1:0];
        if (w_ovf) begin
            w_wb_value = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // A clear landing on the writeback cycle discards the sample, so it cannot count as saturation.
    assign w_sat_event = r_s1_valid && w_ovf && !bus.clr[r_s1_ch];

`ifdef SAT_STICKY_EN
    logic [N_CH-1:0] w_flag;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic signed [ACC_W-1:0] r_acc;
            logic                    w_wr_hit;

            assign w_wr_hit = r_s1_valid && (r_s1_ch == CH_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_acc <= '0;
                end else if (bus.clr[gi]) begin
                    r_acc <= '0;
                end else if (w_wr_hit) begin
                    r_acc <= w_wb_value;
                end
            end

            assign w_acc[gi]                          = r_acc;
            assign bus.acc_data[gi*ACC_W +: ACC_W]    = r_acc;

`ifdef SAT_STICKY_EN
            logic r_flag;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_flag <= 1'b0;
                end else if (w_wr_hit && w_ovf) begin
                    r_flag <= 1'b1;
                end else if (bus.clr[gi]) begin
                    r_flag <= 1'b0;
                end
            end

            assign w_flag[gi] = r_flag;
`endif
        end
    endgenerate

`ifdef SAT_STICKY_EN
    assign bus.sat_flag = w_flag;
`else
    assign bus.sat_flag = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_valid <= 1'b0;
            r_wr_ch    <= '0;
            r_sat_cnt  <= '0;
        end else begin
            r_wr_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_wr_ch <= r_s1_ch;
            end
            if (bus.sat_cnt_clr) begin
                r_sat_cnt <= {7'd0, w_sat_event};
            end else if (w_sat_event && r_sat_cnt != 8'hFF) begin
                r_sat_cnt <= r_sat_cnt + 8'd1;
            end
        end
    end

    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_ch    = r_wr_ch;
    assign bus.sat_cnt  = r_sat_cnt;
endmodule

// File: doc/sat_accum_sched.md
# sat_accum_sched

Shared saturating accumulator with round-robin scheduling. N_CH requesters each stream signed samples into a private accumulator. All channels share one add-and-saturate datapath, and an arbiter grants that datapath to at most one channel per cycle. The block sits between the per-channel sample producers (filter/mixer outputs) and downstream readers of the accumulated totals.

## Interface
- N_CH, 4, number of requesting channels (≥2)
- IN_W, 16, signed sample width
- ACC_W, 24, signed accumulator width (> IN_W)
- CH_W, $clog2(N_CH), local parameter; channel index width

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  N_CH  per-channel sample valid
- in_ready  out  N_CH  per-channel accept (one-hot or zero)
- in_data  in  N_CH*IN_W  channel c at [c*IN_W +: IN_W], signed
- clr  in  N_CH  synchronous clear of accumulator c
- acc_data  out  N_CH*ACC_W  registered accumulators, channel c at [c*ACC_W +: ACC_W]
- wr_valid  out  1  one-cycle pulse per writeback
- wr_ch  out  CH_W  channel of current writeback
- sat_cnt  out  8  saturating-event counter
- sat_cnt_clr  in  1  synchronous clear of sat_cnt
- sat_flag  out  N_CH  sticky per-channel saturation flag (see Configuration)

## Operation
- Arbiter: round-robin pointer `last` (reset 0). Priority order is last+1, last+2, … wrapping mod N_CH.
- in_ready[c] = 1 only for the highest-priority channel with in_valid set. It is combinational from in_valid and `last`. A transfer occurs when in_valid[c] && in_ready[c].
- On a transfer, `last` ← c. With no valid inputs, `last` holds.
- Stage 1 (register): s1_valid, s1_ch, s1_data capture the accepted sample.
- Stage 2 (compute and write):
  - sum = sext(acc[s1_ch], ACC_W+1) + sext(s1_data, ACC_W+1).
  - Overflow when sum[ACC_W] ≠ sum[ACC_W-1].
  - Positive overflow writes 2^(ACC_W-1)-1. Negative overflow writes -2^(ACC_W-1). Otherwise write sum[ACC_W-1:0].
- wr_valid/wr_ch are registered alongside the accumulator write.
- sat_cnt increments on each overflowing writeback and holds at 255.
- sat_cnt_clr zeroes sat_cnt. If an overflow occurs in the same cycle, the result is 1.
- clr[c] zeroes acc[c] next edge.
  - If clr[c] coincides with a stage-2 writeback to c, the clear wins and the sample is discarded.
  - wr_valid still pulses in that case, but no saturation is counted.
- No downstream backpressure: one sample per cycle is sustained indefinitely.

## Timing
- Reset values: acc_data 0, in_ready 0 (no valids), wr_valid 0, wr_ch 0, sat_cnt 0, sat_flag 0, s1_valid 0, `last` 0.
- A sample accepted at edge T is registered into stage 1 at T.
- Its result appears on acc_data and wr_valid at edge T+1. Latency is 2 cycles from the acceptance cycle.
- Back-to-back samples on the same channel need no forwarding: stage 2 reads acc after the previous write has landed.
- Reset asserted mid-stream clears everything asynchronously. The in-flight stage-1 sample is lost.
- After reset, the first grant goes to channel 1 if valid, because `last` is 0.

## Configuration
- SAT_STICKY_EN defined:
  - sat_flag[c] sets on any overflowing writeback to c.
  - It clears only by clr[c] or reset. If set and clear coincide, set wins.
- SAT_STICKY_EN undefined: sat_flag tied to 0 and no flag registers exist.
- sat_cnt is present in both builds.

## Test plan
- Reset: hold rst_n=0 with random inputs → all outputs 0, in_ready=0. Release → first grant to ch1 when ch0–ch3 all valid.
- Accumulate: ch0 sends 100 then -30 on consecutive cycles → wr_valid two pulses with wr_ch=0; acc_data ch0 = 100 then 70.
- Fairness: all in_valid=1 for 8 cycles → grants 1,2,3,0,1,2,3,0; in_ready always one-hot.
- Positive saturation (ACC_W=24): ch2 sends 32767 ×256 → acc 8388352, sat_cnt 0. One more 32767 → acc 8388607, sat_cnt 1, sat_flag[2]=1 (macro on). A further -1 → 8388606, flag stays set.
- Negative edge: ch3 sends -32768 ×256 → acc -8388608, no saturation. Then -1 → acc -8388608, sat_cnt+1.
- Collisions: clr[0] in the writeback cycle of a ch0 sample → acc 0, sat_cnt unchanged. sat_cnt at 255 plus overflow → stays 255. sat_cnt_clr together with overflow → 1.
